mips_instr_encoder: RTL and testbench



---
 rtl/mips_isa_pkg.sv | 59 +++++
 rtl/mips_instr_fmt.sv | 57 +++++
 rtl/mips_instr_encoder.sv | 110 +++++++++++
 tb/tb_mips_instr_encoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: symbolic op enum plus opcode/funct field values
// used by both the decoder and the program-loader encoder.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
        OP_SLTI, OP_SLTIU, OP_J, OP_JAL, OP_LUI
    } op_e;

    localparam logic [4:0] OP_INVALID = 5'd31;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_fmt.sv
// Combinational op + fields -> 32-bit MIPS word; valid is low for op codes
// outside the supported set.
module mips_instr_fmt
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        valid
);

    always_comb begin
        word  = '0;
        valid = 1'b1;
        case (op)
            OP_ADD:   word = r_word(rs, rt, rd, shamt, FN_ADD);
            OP_ADDU:  word = r_word(rs, rt, rd, shamt, FN_ADDU);
            OP_SUB:   word = r_word(rs, rt, rd, shamt, FN_SUB);
            OP_SUBU:  word = r_word(rs, rt, rd, shamt, FN_SUBU);
            OP_AND:   word = r_word(rs, rt, rd, shamt, FN_AND);
            OP_OR:    word = r_word(rs, rt, rd, shamt, FN_OR);
            OP_XOR:   word = r_word(rs, rt, rd, shamt, FN_XOR);
            OP_NOR:   word = r_word(rs, rt, rd, shamt, FN_NOR);
            OP_SLT:   word = r_word(rs, rt, rd, shamt, FN_SLT);
            OP_SLTU:  word = r_word(rs, rt, rd, shamt, FN_SLTU);
            // Constant shifts take the amount from shamt, variable shifts from rs.
            OP_SLL:   word = r_word('0, rt, rd, shamt, FN_SLL);
            OP_SRL:   word = r_word('0, rt, rd, shamt, FN_SRL);
            OP_SRA:   word = r_word('0, rt, rd, shamt, FN_SRA);
            OP_SLLV:  word = r_word(rs, rt, rd, '0, FN_SLLV);
            OP_SRLV:  word = r_word(rs, rt, rd, '0, FN_SRLV);
            OP_SRAV:  word = r_word(rs, rt, rd, '0, FN_SRAV);
            OP_JR:    word = r_word(rs, '0, '0, '0, FN_JR);
            OP_LW:    word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:    word = i_word(OPC_SW, rs, rt, imm);
            OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm);
            OP_BNE:   word = i_word(OPC_BNE, rs, rt, imm);
            OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm);
            OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm);
            OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm);
            OP_XORI:  word = i_word(OPC_XORI, rs, rt, imm);
            OP_SLTI:  word = i_word(OPC_SLTI, rs, rt, imm);
            OP_SLTIU: word = i_word(OPC_SLTIU, rs, rt, imm);
            OP_LUI:   word = i_word(OPC_LUI, '0, rt, imm);
            OP_J:     word = {OPC_J, target};
            OP_JAL:   word = {OPC_JAL, target};
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instruction requests and writes encoded
// words sequentially into instruction memory from word 0.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_e          state, state_nx;
    logic [31:0]     fmt_word;
    logic            fmt_valid;
    logic            accept;
    logic            start_load;
    logic            write;
    logic            full;
    logic [ADDR_W:0] count_nx;

    mips_instr_fmt u_fmt (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (fmt_word),
        .valid  (fmt_valid)
    );

    assign in_ready   = (state == S_LOAD);
    assign busy       = (state == S_LOAD);
    assign accept     = in_valid & in_ready;
    assign start_load = start & (state != S_LOAD);
    assign write      = accept & fmt_valid;
    assign count_nx   = count + 1'b1;
    assign full       = write & (count_nx == FULL_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LOAD;
            S_LOAD: if (accept && (!fmt_valid || in_last || full)) state_nx = S_DONE;
            S_DONE: if (start) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start_load) begin
                count <= '0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else if (write) begin
                imem_we    <= 1'b1;
                imem_addr  <= count[ADDR_W-1:0];
                imem_wdata <= fmt_word;
                count      <= count_nx;
                if (in_last) begin
                    done <= 1'b1;
                end else if (full) begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end else if (accept) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: a 64-word instance for encoding and
// session control, plus a 4-word instance sharing the stimulus for overflow.
module tb_mips_instr_encoder;
    import mips_isa_pkg::*;

    logic        clk, rst_n, start, in_valid, in_last;
    logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        ready, we, busy, done, err;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [6:0]  count;

    logic        ready2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int checks = 0;
    int passed = 0;

    mips_instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(we), .imem_addr(addr), .imem_wdata(wdata), .count(count),
        .busy(busy), .done(done), .err(err)
    );

    mips_instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .count(count2),
        .busy(busy2), .done(done2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                           input logic [25:0] tgt, input logic last);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
    endtask

    task automatic idle_req();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; idle_req();
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if ({we, ready, busy, done, err} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {we, ready, busy, done, err}); else passed++;
        checks++; if ({addr, wdata, count} !== '0) $display("FAIL reset_data got %h/%h/%0d want 0", addr, wdata, count); else passed++;
    endtask

    task automatic test_encoding();
        pulse_start();
        checks++; if (ready !== 1'b1 || busy !== 1'b1) $display("FAIL load_ready got %b%b want 11", ready, busy); else passed++;
        set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        step();
        checks++; if (we !== 1'b1 || addr !== 6'd0) $display("FAIL add_we got we=%b addr=%0d want 1/0", we, addr); else passed++;
        checks++; if (wdata !== 32'h00221820) $display("FAIL add_data got %h want 00221820", wdata); else passed++;
        checks++; if (count !== 7'd1) $display("FAIL add_count got %0d want 1", count); else passed++;
    endtask

    task automatic test_back_to_back();
        set_req(OP_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
        step();
        checks++; if (we !== 1'b1 || addr !== 6'd1 || wdata !== 32'h20080005) $display("FAIL addi got we=%b addr=%0d data=%h want 1/1/20080005", we, addr, wdata); else passed++;
        set_req(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        step();
        checks++; if (we !== 1'b1 || addr !== 6'd2 || wdata !== 32'h08000010) $display("FAIL j_last got we=%b addr=%0d data=%h want 1/2/08000010", we, addr, wdata); else passed++;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || count !== 7'd3) $display("FAIL j_done got done=%b busy=%b err=%b count=%0d want 1/0/0/3", done, busy, err, count); else passed++;
        idle_req();
        step();
        checks++; if (we !== 1'b0 || done !== 1'b1) $display("FAIL strobe_once got we=%b done=%b want 0/1", we, done); else passed++;
    endtask

    task automatic test_forced_zero();
        pulse_start();
        checks++; if (count !== 7'd0 || done !== 1'b0 || busy !== 1'b1) $display("FAIL restart got count=%0d done=%b busy=%b want 0/0/1", count, done, busy); else passed++;
        set_req(OP_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        step();
        checks++; if (wdata !== 32'h00011100 || addr !== 6'd0) $display("FAIL sll got %h@%0d want 00011100@0", wdata, addr); else passed++;
        set_req(OP_JR, 5'd31, 5'd5, 5'd6, 5'd3, 16'h1234, 26'h0, 1'b0);
        step();
        checks++; if (wdata !== 32'h03E00008) $display("FAIL jr got %h want 03E00008", wdata); else passed++;
        set_req(OP_SRAV, 5'd2, 5'd3, 5'd4, 5'd9, 16'h0, 26'h0, 1'b0);
        step();
        checks++; if (wdata !== 32'h00432007) $display("FAIL srav got %h want 00432007", wdata); else passed++;
        set_req(OP_LUI, 5'd5, 5'd9, 5'd7, 5'd7, 16'h1234, 26'h0, 1'b0);
        step();
        checks++; if (wdata !== 32'h3C091234) $display("FAIL lui got %h want 3C091234", wdata); else passed++;
        set_req(OP_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'h0, 1'b1);
        step();
        checks++; if (wdata !== 32'hAFBFFFFC || addr !== 6'd4 || done !== 1'b1) $display("FAIL sw_last got %h@%0d done=%b want AFBFFFFC@4 1", wdata, addr, done); else passed++;
        idle_req();
        step();
    endtask

    task automatic test_invalid_op();
        pulse_start();
        set_req(OP_INVALID, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
        step();
        checks++; if (we !== 1'b0 || err !== 1'b1 || done !== 1'b1) $display("FAIL invalid got we=%b err=%b done=%b want 0/1/1", we, err, done); else passed++;
        checks++; if (ready !== 1'b0 || count !== 7'd0) $display("FAIL invalid_state got ready=%b count=%0d want 0/0", ready, count); else passed++;
        idle_req();
        step();
        checks++; if (err !== 1'b1 || done !== 1'b1) $display("FAIL err_sticky got err=%b done=%b want 1/1", err, done); else passed++;
        pulse_start();
        checks++; if (err !== 1'b0 || done !== 1'b0 || count !== 7'd0 || busy !== 1'b1) $display("FAIL err_clear got err=%b done=%b count=%0d busy=%b want 0/0/0/1", err, done, count, busy); else passed++;
        set_req(OP_OR, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        step();
        idle_req();
        step();
    endtask

    task automatic test_start_with_valid();
        start = 1'b1;
        set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        step();
        start = 1'b0;
        checks++; if (we !== 1'b0 || count !== 7'd0 || busy !== 1'b1) $display("FAIL start_valid got we=%b count=%0d busy=%b want 0/0/1", we, count, busy); else passed++;
        step();
        checks++; if (we !== 1'b1 || addr !== 6'd0 || done !== 1'b1) $display("FAIL start_valid_next got we=%b addr=%0d done=%b want 1/0/1", we, addr, done); else passed++;
        idle_req();
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            for (int i = 0; i < 4; i++) begin
                set_req(OP_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0, (pass == 1) && (i == 3));
                exp_w = 32'h24010000 | 32'(i);
                step();
                checks++; if (we2 !== 1'b1 || addr2 !== 2'(i) || wdata2 !== exp_w) $display("FAIL ovf_write%0d_%0d got we=%b addr=%0d data=%h want 1/%0d/%h", pass, i, we2, addr2, wdata2, i, exp_w); else passed++;
            end
            idle_req();
            checks++; if (err2 !== (pass == 0) || done2 !== 1'b1 || busy2 !== 1'b0 || count2 !== 3'd4) $display("FAIL ovf_end%0d got err=%b done=%b busy=%b count=%0d want %0d/1/0/4", pass, err2, done2, busy2, count2, (pass == 0)); else passed++;
            step();
            checks++; if (we2 !== 1'b0) $display("FAIL ovf_nowrite%0d got we=%b want 0", pass, we2); else passed++;
        end
    endtask

    task automatic test_reset_mid_load();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pulse_start();
        set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || ready !== 1'b0) $display("FAIL rst_async got busy=%b ready=%b want 0/0", busy, ready); else passed++;
        step();
        checks++; if ({we, done, err} !== 3'b0 || {addr, wdata, count} !== '0) $display("FAIL rst_mid got we=%b addr=%0d data=%h count=%0d want all 0", we, addr, wdata, count); else passed++;
        idle_req();
        rst_n = 1'b1;
        step();
        pulse_start();
        set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        step();
        checks++; if (we !== 1'b1 || addr !== 6'd0 || wdata !== 32'h00221820 || count !== 7'd1) $display("FAIL rst_resume got we=%b addr=%0d data=%h count=%0d want 1/0/00221820/1", we, addr, wdata, count); else passed++;
        idle_req();
        step();
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_back_to_back();
        test_forced_zero();
        test_invalid_op();
        test_start_with_valid();
        test_overflow();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
